axis_width_downconv: RTL

AXIS_WIDTH_DOWNCONV -- requirements
Module: axis_width_downconv

---
 rtl/rfsoc_config_pkg.sv | 8 +
 rtl/axis_width_downconv.sv | 117 +++++++++++
 2 files changed

// File: rtl/rfsoc_config_pkg.sv
// Shared RFSoC stream-width constants used by the PL data path.
// Exports ps_axis_width (PS-side word) and adc_axis_width (ADC beat).
package rfsoc_config;

  localparam int ps_axis_width  = 32;
  localparam int adc_axis_width = 128;

endpackage

// File: rtl/axis_width_downconv.sv
// AXI-Stream width down-converter: splits IN_WIDTH beats into OUT_WIDTH
// words in LSB- or MSB-first order and frames every PKT_BEATS beats with
// tlast.
// Ports: pl_clk, rst (async, active-low), msb_first, s_axis_* (slave),
// m_axis_* (master), pkt_count (only with AXIS_DOWNCONV_STATS_EN).
module axis_width_downconv
  import rfsoc_config::*;
#(
  parameter int IN_WIDTH  = adc_axis_width,
  parameter int OUT_WIDTH = ps_axis_width,
  parameter int PKT_BEATS = 16
) (
  input  logic                 pl_clk,
  input  logic                 rst,
  input  logic                 msb_first,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
`ifdef AXIS_DOWNCONV_STATS_EN
  output logic [31:0]          pkt_count,
`endif
  input  logic                 m_axis_tready
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IW =
    RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int BW =
    PKT_BEATS > 1 ? $clog2(PKT_BEATS) : 1;
  localparam logic [IW-1:0] IDX_LAST =
    IW'(RATIO - 1);
  localparam logic [BW-1:0] BCNT_LAST =
    BW'(PKT_BEATS - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 ||
      RATIO < 1 || PKT_BEATS < 1) begin : g_bad_cfg
    $error("axis_width_downconv: bad width/packet config");
  end

  logic [RATIO-1:0][OUT_WIDTH-1:0] hold;
  logic          ord;
  logic          hv;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic [IW-1:0] sel;
  logic          last_word;
  logic          s_hs;
  logic          m_hs;

  assign last_word = (idx == IDX_LAST);
  assign s_axis_tready =
    !hv || (m_axis_tready && last_word);
  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign m_hs = hv && m_axis_tready;

  // Order is taken from the latched copy so a
  // mid-beat msb_first change cannot reorder words.
  assign sel = ord ? (IDX_LAST - idx) : idx;

  assign m_axis_tvalid = hv;
  assign m_axis_tdata  = hold[sel];
  assign m_axis_tlast  =
    hv && last_word && (bcnt == BCNT_LAST);

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      ord  <= 1'b0;
    end else if (s_hs) begin
      hold <= s_axis_tdata;
      ord  <= msb_first;
    end
  end

  // A beat accepted on the final-word handshake
  // keeps hv high: no bubble between beats.
  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      hv <= 1'b0;
    end else if (s_hs) begin
      hv <= 1'b1;
    end else if (m_hs && last_word) begin
      hv <= 1'b0;
    end
  end

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (m_hs) begin
      idx <= last_word ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      bcnt <= '0;
    end else if (m_hs && last_word) begin
      bcnt <= (bcnt == BCNT_LAST) ?
        '0 : bcnt + 1'b1;
    end
  end

`ifdef AXIS_DOWNCONV_STATS_EN
  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      pkt_count <= '0;
    end else if (m_hs && m_axis_tlast) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule
